ldpc_min_sum_decoder: RTL and testbench

LDPC_MIN_SUM_DECODER -- requirements
Module: ldpc_min_sum_decoder

---
 rtl/ldpc_min_sum_decoder.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_ldpc_min_sum_decoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_min_sum_decoder.sv
// ----------------------------------------------------------------------------
// ldpc_min_sum_decoder
//
// Iterative min-sum LDPC decoder for a small parity-check matrix held as a
// parameter.  One check-node row is processed per cycle, then one
// variable-node column per cycle, then a single syndrome check.  An
// iteration therefore takes M_ROWS + N_COLS + 1 cycles.
//
// Ports
//   clk         single clock, rising edge
//   reset       synchronous, active-high reset
//   start       decode request, only sampled while idle
//   llr_in      channel LLRs, column c at [c*LLR_W +: LLR_W], positive = bit 0
//   busy        high in every state except IDLE
//   done        one-cycle completion pulse
//   decoded     hard decisions, bit c = column c
//   parity_ok   final syndrome was all-zero
//   iter_count  iterations executed in the last decode
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start, results held
// ROW   | check-node update of row row_q (one row per cycle)
// COL   | variable-node total and hard decision of column col_q
// CHECK | syndrome test, iteration count update
// DONE  | done pulse, back to IDLE next cycle
// ----------------------------------------------------------------------------
module ldpc_min_sum_decoder #(
    parameter int                         N_COLS   = 6,
    parameter int                         M_ROWS   = 3,
    parameter int                         LLR_W    = 8,
    parameter int                         MAX_ITER = 8,
    parameter logic [M_ROWS*N_COLS-1:0]   H_MATRIX = 18'h3158B
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N_COLS*LLR_W-1:0]   llr_in,
    output logic                      busy,
    output logic                      done,
    output logic [N_COLS-1:0]         decoded,
    output logic                      parity_ok,
    output logic [7:0]                iter_count
);

    localparam int ACC_W = LLR_W + 8;
    localparam int RW    = (M_ROWS > 1) ? $clog2(M_ROWS) : 1;
    localparam int CW    = (N_COLS > 1) ? $clog2(N_COLS) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(2**(LLR_W-1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = -SAT_MAX;
    localparam logic [RW-1:0]           ROW_LAST = RW'(M_ROWS - 1);
    localparam logic [CW-1:0]           COL_LAST = CW'(N_COLS - 1);
    localparam logic [7:0]              ITER_LIM = 8'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW,
        S_COL,
        S_CHECK,
        S_DONE
    } state_t;

    // Clamp to the symmetric range so the most-negative code never appears;
    // this keeps |x| representable in LLR_W bits for the min search.
    function automatic logic signed [LLR_W-1:0] sat(input logic signed [ACC_W-1:0] x);
        if (x > SAT_MAX) begin
            return SAT_MAX[LLR_W-1:0];
        end else if (x < SAT_MIN) begin
            return SAT_MIN[LLR_W-1:0];
        end else begin
            return x[LLR_W-1:0];
        end
    endfunction

    function automatic logic signed [ACC_W-1:0] sx(input logic signed [LLR_W-1:0] x);
        return {{(ACC_W-LLR_W){x[LLR_W-1]}}, x};
    endfunction

    state_t                   state_q, state_d;
    logic [RW-1:0]            row_q, row_d;
    logic [CW-1:0]            col_q, col_d;
    logic [7:0]               iter_q, iter_d;
    logic                     parity_ok_q, parity_ok_d;
    logic                     busy_q, done_q;
    logic [N_COLS-1:0]        decoded_q;

    logic signed [LLR_W-1:0]  ch_q    [N_COLS];
    logic signed [LLR_W-1:0]  total_q [N_COLS];
    logic signed [LLR_W-1:0]  c2v_q   [M_ROWS][N_COLS];

    logic [N_COLS-1:0]        h_row   [M_ROWS];
    logic signed [LLR_W-1:0]  llr_ch  [N_COLS];

    for (genvar gr = 0; gr < M_ROWS; gr++) begin : g_hrow
        assign h_row[gr] = H_MATRIX[gr*N_COLS +: N_COLS];
    end

    // Channel values are clamped on capture as well, so a -2^(LLR_W-1)
    // input is stored as the symmetric minimum.
    for (genvar gc = 0; gc < N_COLS; gc++) begin : g_llr
        assign llr_ch[gc] = sat(sx(llr_in[gc*LLR_W +: LLR_W]));
    end

    // ------------------------------------------------------------------
    // Check-node update for the current row
    // ------------------------------------------------------------------
    logic [N_COLS-1:0]        row_mask;
    logic                     row_deg_ge2;
    logic signed [LLR_W-1:0]  v2c      [N_COLS];
    logic [LLR_W-1:0]         v2c_mag  [N_COLS];
    logic [N_COLS-1:0]        v2c_neg;
    logic [LLR_W-1:0]         oth_min  [N_COLS];
    logic [N_COLS-1:0]        oth_neg;
    logic signed [LLR_W-1:0]  c2v_new  [N_COLS];

    always_comb begin
        row_mask    = h_row[row_q];
        row_deg_ge2 = ($countones(row_mask) > 1);
        v2c_neg     = '0;
        oth_neg     = '0;
        for (int c = 0; c < N_COLS; c++) begin
            v2c[c]     = sat(sx(total_q[c]) - sx(c2v_q[row_q][c]));
            v2c_neg[c] = v2c[c][LLR_W-1];
            v2c_mag[c] = v2c_neg[c] ? -v2c[c] : v2c[c];
        end
        for (int c = 0; c < N_COLS; c++) begin
            oth_min[c] = '1;
            for (int k = 0; k < N_COLS; k++) begin
                if (k != c && row_mask[k]) begin
                    if (v2c_mag[k] < oth_min[c]) begin
                        oth_min[c] = v2c_mag[k];
                    end
                    oth_neg[c] = oth_neg[c] ^ v2c_neg[k];
                end
            end
            if (row_mask[c] && row_deg_ge2) begin
                c2v_new[c] = oth_neg[c] ? -$signed(oth_min[c]) : $signed(oth_min[c]);
            end else begin
                c2v_new[c] = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Variable-node total for the current column
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0]  col_acc;
    logic signed [LLR_W-1:0]  col_total;

    always_comb begin
        col_acc = sx(ch_q[col_q]);
        for (int r = 0; r < M_ROWS; r++) begin
            if (h_row[r][col_q]) begin
                col_acc = col_acc + sx(c2v_q[r][col_q]);
            end
        end
        col_total = sat(col_acc);
    end

    logic [M_ROWS-1:0] syndrome;

    always_comb begin
        syndrome = '0;
        for (int r = 0; r < M_ROWS; r++) begin
            syndrome[r] = ^(h_row[r] & decoded_q);
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        iter_d      = iter_q;
        parity_ok_d = parity_ok_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ROW;
                    row_d   = '0;
                    iter_d  = '0;
                end
            end
            S_ROW: begin
                if (row_q == ROW_LAST) begin
                    state_d = S_COL;
                    col_d   = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            S_COL: begin
                if (col_q == COL_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            S_CHECK: begin
                iter_d = iter_q + 8'd1;
                if (syndrome == '0) begin
                    parity_ok_d = 1'b1;
                    state_d     = S_DONE;
                end else if (iter_d == ITER_LIM) begin
                    parity_ok_d = 1'b0;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_ROW;
                    row_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            iter_q      <= '0;
            parity_ok_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            iter_q      <= iter_d;
            parity_ok_q <= parity_ok_d;
            // Registered flags track the state being entered, so they line
            // up with state_q in the following cycle.
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
        end
    end

    // ------------------------------------------------------------------
    // Message and decision storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            decoded_q <= '0;
            for (int c = 0; c < N_COLS; c++) begin
                ch_q[c]    <= '0;
                total_q[c] <= '0;
                for (int r = 0; r < M_ROWS; r++) begin
                    c2v_q[r][c] <= '0;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        for (int c = 0; c < N_COLS; c++) begin
                            ch_q[c]    <= llr_ch[c];
                            total_q[c] <= llr_ch[c];
                            for (int r = 0; r < M_ROWS; r++) begin
                                c2v_q[r][c] <= '0;
                            end
                        end
                    end
                end
                S_ROW: begin
                    for (int c = 0; c < N_COLS; c++) begin
                        c2v_q[row_q][c] <= c2v_new[c];
                    end
                end
                S_COL: begin
                    total_q[col_q]   <= col_total;
                    decoded_q[col_q] <= col_total[LLR_W-1];
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign decoded    = decoded_q;
    assign parity_ok  = parity_ok_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_ldpc_min_sum_decoder.sv
// ----------------------------------------------------------------------------
// tb_ldpc_min_sum_decoder
//
// Directed vectors with hand-computed results for the default 3x6 code.
// dut_a uses the default iteration limit, dut_b is limited to one iteration;
// both share the same stimulus.
// ----------------------------------------------------------------------------
module tb_ldpc_min_sum_decoder;

    localparam int N  = 6;
    localparam int LW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [N*LW-1:0]   llr_in;

    logic              busy_a, done_a, par_a;
    logic [N-1:0]      dec_a;
    logic [7:0]        iter_a;
    logic              busy_b, done_b, par_b;
    logic [N-1:0]      dec_b;
    logic [7:0]        iter_b;

    int n_vec  = 0;
    int n_miss = 0;

    int done_edge_a, done_edge_b, pulses_a, pulses_b;
    logic              busy_at_rst, done_at_rst, par_at_rst;
    logic [N-1:0]      dec_at_rst;
    logic [7:0]        iter_at_rst;

    always #5 clk = ~clk;

    ldpc_min_sum_decoder dut_a (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .llr_in     (llr_in),
        .busy       (busy_a),
        .done       (done_a),
        .decoded    (dec_a),
        .parity_ok  (par_a),
        .iter_count (iter_a)
    );

    ldpc_min_sum_decoder #(.MAX_ITER(1)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .llr_in     (llr_in),
        .busy       (busy_b),
        .done       (done_b),
        .decoded    (dec_b),
        .parity_ok  (par_b),
        .iter_count (iter_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [N*LW-1:0] pack(input int a0, input int a1, input int a2,
                                             input int a3, input int a4, input int a5);
        logic [N*LW-1:0] v;
        v = {LW'(a5), LW'(a4), LW'(a3), LW'(a2), LW'(a1), LW'(a0)};
        return v;
    endfunction

    // Start a decode, then watch n_edges further edges.  Edge numbers count
    // from the start-sampling edge (edge 0).  A zero for restart/rst/chg
    // means that event is not used.
    task automatic run_decode(input logic [N*LW-1:0] llr, input int restart_edge,
                              input int rst_edge, input int chg_edge,
                              input logic [N*LW-1:0] llr_alt, input int n_edges);
        llr_in = llr;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy_a), 1);
        done_edge_a = -1;
        done_edge_b = -1;
        pulses_a    = 0;
        pulses_b    = 0;
        for (int e = 1; e <= n_edges; e++) begin
            start = (e == restart_edge);
            reset = (e == rst_edge);
            if (e == chg_edge) llr_in = llr_alt;
            @(posedge clk);
            #1;
            if (done_a) begin
                pulses_a++;
                if (done_edge_a < 0) done_edge_a = e;
            end
            if (done_b) begin
                pulses_b++;
                if (done_edge_b < 0) done_edge_b = e;
            end
            if (e == rst_edge) begin
                busy_at_rst = busy_a;
                done_at_rst = done_a;
                par_at_rst  = par_a;
                dec_at_rst  = dec_a;
                iter_at_rst = iter_a;
            end
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic chk_a(input string tag, input int edge_exp, input int dec_exp,
                         input int par_exp, input int iter_exp);
        chk({tag, "_done_edge"}, done_edge_a, edge_exp);
        chk({tag, "_pulses"},    pulses_a, 1);
        chk({tag, "_decoded"},   int'(dec_a), dec_exp);
        chk({tag, "_parity_ok"}, int'(par_a), par_exp);
        chk({tag, "_iter"},      int'(iter_a), iter_exp);
        chk({tag, "_idle"},      int'(busy_a), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        llr_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   int'(busy_a), 0);
        chk("rst_done",   int'(done_a), 0);
        chk("rst_dec",    int'(dec_a), 0);
        chk("rst_parity", int'(par_a), 0);
        chk("rst_iter",   int'(iter_a), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // all +20: already a codeword, one iteration
        run_decode(pack(20, 20, 20, 20, 20, 20), 0, 0, 0, '0, 40);
        chk_a("all20", 10, 0, 1, 1);
        chk("all20_b_done_edge", done_edge_b, 10);

        // weak error on c0 corrected in one iteration
        run_decode(pack(-5, 20, 20, 20, 20, 20), 0, 0, 0, '0, 40);
        chk_a("c0weak", 10, 0, 1, 1);

        // nonzero codeword c0,c1,c4
        run_decode(pack(-100, -100, 100, 100, 100, 100), 0, 0, 0, '0, 40);
        chk_a("cw13", 10, 'b010011, 1, 1);

        // strong error on c3: two iterations by default, limit reached on dut_b
        run_decode(pack(100, 100, 100, -127, 100, 100), 0, 0, 0, '0, 40);
        chk_a("c3err", 20, 0, 1, 2);
        chk("c3err_b_done_edge", done_edge_b, 10);
        chk("c3err_b_pulses",    pulses_b, 1);
        chk("c3err_b_decoded",   int'(dec_b), 'b001000);
        chk("c3err_b_parity_ok", int'(par_b), 0);
        chk("c3err_b_iter",      int'(iter_b), 1);

        // all +127: totals saturate instead of wrapping
        run_decode(pack(127, 127, 127, 127, 127, 127), 0, 0, 0, '0, 40);
        chk_a("all127", 10, 0, 1, 1);

        // all -128: clamped to -127 on capture, converges to all-zero word
        run_decode(pack(-128, -128, -128, -128, -128, -128), 0, 0, 0, '0, 40);
        chk_a("allneg", 10, 0, 1, 1);

        // start re-asserted at edge 4 and llr_in changed at edge 2: both ignored
        run_decode(pack(-100, -100, 100, 100, 100, 100), 4, 0, 2,
                   pack(20, 20, 20, 20, 20, 20), 40);
        chk_a("restart", 10, 'b010011, 1, 1);

        // reset at edge 5 aborts the decode with no done pulse
        run_decode(pack(-100, -100, 100, 100, 100, 100), 0, 5, 0, '0, 40);
        chk("abort_busy",    int'(busy_at_rst), 0);
        chk("abort_done",    int'(done_at_rst), 0);
        chk("abort_dec",     int'(dec_at_rst), 0);
        chk("abort_parity",  int'(par_at_rst), 0);
        chk("abort_iter",    int'(iter_at_rst), 0);
        chk("abort_pulses",  pulses_a, 0);
        chk("abort_dec_end", int'(dec_a), 0);

        // clean decode after the abort
        run_decode(pack(100, 100, 100, -127, 100, 100), 0, 0, 0, '0, 40);
        chk_a("post_abort", 20, 0, 1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
